sequence_feeder: RTL
====================

// Module: sequence_feeder
// PURPOSE
//  Upstream stage of state_machine: buffers a robot input sequence of WIDTH-bit numbers and replays it,
//  one entry per step, onto state_machine's number input.
//  Watches state_machine's state_display and aborts replay on game over (2'b11).
//  Buffer is loaded by a host/file loader, then played on a start pulse. Playback is non-destructive, so it can be replayed.
// PARAMETERS
//  WIDTH        4   bits per sequence entry (matches number)
//  DEPTH        6   max entries held
//  HOLD_CYCLES  1   clock cycles each entry is held on number (>=1)
//  IDLE_VALUE   0   value driven on number when not playing
//  localparam CW = $clog2(DEPTH+1)   count width
// PORTS
//  clock        in   1      system clock, all logic on rising edge
//  reset        in   1      synchronous, active-high
//  wr_en        in   1      write wr_data into buffer (honoured in IDLE only)
//  wr_data      in   WIDTH  entry to append
//  start        in   1      begin playback (single-cycle pulse)
//  clear        in   1      empty buffer, stop playback
//  game_state   in   2      state_display from state_machine
//  number       out  WIDTH  registered value fed to state_machine.number
//  step_strobe  out  1      high on first cycle each new entry is on number
//  busy         out  1      high while in PLAY
//  done         out  1      1-cycle pulse when all entries were played
//  aborted      out  1      sticky: playback stopped by game over
//  overflow     out  1      sticky: write attempted while full
//  full         out  1      count == DEPTH
//  empty        out  1      count == 0
//  count        out  CW     entries stored
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; count=0; wr_ptr=0.
//   - number=IDLE_VALUE.
//   - step_strobe, busy, done, aborted, overflow = 0.
//   - empty=1; full=0.
//  Priority: reset > clear > start > wr_en.
//  FSM states: IDLE, PLAY. All outputs are registered. full, empty and busy are decoded from registered state/count.
//  IDLE, write path:
//   - wr_en & !full: buf[wr_ptr]<=wr_data; wr_ptr++; count++.
//   - wr_en & full: data dropped; overflow<=1.
//   - wr_en while in PLAY: ignored, no overflow.
//  IDLE, start:
//   - start & count>0: next edge state=PLAY; rd_idx=0; number=buf[0]; step_strobe=1; hold=HOLD_CYCLES-1; aborted<=0.
//   - start & count==0: ignored; no busy, no done.
//   - start & wr_en in the same cycle: start wins; write dropped; overflow unchanged.
//  PLAY:
//   - Each entry is held exactly HOLD_CYCLES cycles. step_strobe is high only on the first of those cycles.
//   - When hold expires and rd_idx<count-1: rd_idx++, next entry driven.
//   - When hold expires on the last entry: state=IDLE; number=IDLE_VALUE; done=1 for one cycle.
//   - start during PLAY: ignored.
//  Abort:
//   - In PLAY, game_state==2'b11 sampled on an edge -> next edge state=IDLE; number=IDLE_VALUE; aborted<=1; done stays 0.
//   - Other game_state codes (01, 10, 00) have no effect on playback.
//   - Abort and last-entry expiry in the same cycle: abort wins, no done.
//  clear:
//   - Any state -> count=0; wr_ptr=0; state=IDLE; number=IDLE_VALUE.
//   - overflow<=0 and aborted<=0.
//   - No done.
//  Buffer contents survive done and abort. The next start replays from entry 0.
//  Reset mid-PLAY: reset values at the next edge; buffer contents are discarded (count=0).
// TESTING
//  1 Reset; write 1,2,3,4,5,6 -> count=6, full=1. 7th write (9) -> overflow=1, count=6, buf[5]=6.
//  2 HOLD_CYCLES=1, start -> number=1..6 on 6 consecutive cycles from edge after start; step_strobe=1 each cycle; then done=1 for 1 cycle, number=0, busy=0.
//  3 HOLD_CYCLES=3, entries 7,8 -> 7 held 3 cycles, 8 held 3 cycles; step_strobe only on first cycle of each; done on cycle 7.
//  4 Play 6 entries; set game_state=2'b11 while number=3 -> next edge number=0, aborted=1, done never pulses.
//    Then restart -> number=1 first, aborted=0.
//  5 start with count=0 -> busy stays 0, no done.
//    clear mid-PLAY -> next edge IDLE, count=0, empty=1, number=0.
//  6 reset asserted mid-PLAY for 1 cycle -> all outputs at reset values next edge.
//    wr_en during PLAY -> count unchanged, overflow=0.

Source files
------------

// File: rtl/sequence_feeder.sv
// sequence_feeder: buffers a sequence of numbers and replays it one entry per step,
// aborting playback when the downstream state machine reports game over.
module sequence_feeder #(
   parameter int WIDTH       = 4,
   parameter int DEPTH       = 6,
   parameter int HOLD_CYCLES = 1,
   parameter int IDLE_VALUE  = 0,
   localparam int CW = $clog2(DEPTH+1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             start,
   input  logic             clear,
   input  logic [1:0]       game_state,
   output logic [WIDTH-1:0] number,
   output logic             step_strobe,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic             overflow,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [WIDTH-1:0] IDLE_NUM = WIDTH'(IDLE_VALUE);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES-1);

   typedef enum logic {IDLE, PLAY} state_t;

   state_t state, state_n;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr, wr_ptr_n, rd_idx, rd_idx_n;
   logic [HW-1:0] hold, hold_n;
   logic [CW-1:0] count_n;
   logic [WIDTH-1:0] number_n;
   logic strobe_n, done_n, aborted_n, overflow_n, we;

   assign busy  = state == PLAY;
   assign full  = count == CW'(DEPTH);
   assign empty = count == '0;

   always_comb begin
      state_n    = state;
      count_n    = count;
      wr_ptr_n   = wr_ptr;
      rd_idx_n   = rd_idx;
      hold_n     = hold;
      number_n   = number;
      strobe_n   = 1'b0;
      done_n     = 1'b0;
      aborted_n  = aborted;
      overflow_n = overflow;
      we         = 1'b0;
      if (clear) begin
         state_n    = IDLE;
         count_n    = '0;
         wr_ptr_n   = '0;
         number_n   = IDLE_NUM;
         aborted_n  = 1'b0;
         overflow_n = 1'b0;
      end else if (state == IDLE) begin
         if (start && !empty) begin
            state_n   = PLAY;
            rd_idx_n  = '0;
            number_n  = mem[0];
            strobe_n  = 1'b1;
            hold_n    = HOLD_LOAD;
            aborted_n = 1'b0;
         end else if (wr_en) begin
            overflow_n = overflow | full;
            we         = !full;
            wr_ptr_n   = full ? wr_ptr : wr_ptr + PW'(1);
            count_n    = full ? count : count + CW'(1);
         end
      end else if (game_state == 2'b11) begin
         state_n   = IDLE;
         number_n  = IDLE_NUM;
         aborted_n = 1'b1;
      end else if (hold != '0) begin
         hold_n = hold - HW'(1);
      end else if (CW'(rd_idx) + CW'(1) < count) begin
         rd_idx_n = rd_idx + PW'(1);
         number_n = mem[rd_idx + PW'(1)];
         strobe_n = 1'b1;
         hold_n   = HOLD_LOAD;
      end else begin
         state_n  = IDLE;
         number_n = IDLE_NUM;
         done_n   = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         count       <= '0;
         wr_ptr      <= '0;
         rd_idx      <= '0;
         hold        <= '0;
         number      <= IDLE_NUM;
         step_strobe <= 1'b0;
         done        <= 1'b0;
         aborted     <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         state       <= state_n;
         count       <= count_n;
         wr_ptr      <= wr_ptr_n;
         rd_idx      <= rd_idx_n;
         hold        <= hold_n;
         number      <= number_n;
         step_strobe <= strobe_n;
         done        <= done_n;
         aborted     <= aborted_n;
         overflow    <= overflow_n;
      end
   end

   // Storage is not reset: count alone decides which entries are valid.
   always_ff @(posedge clock) begin
      if (we) mem[wr_ptr] <= wr_data;
   end
endmodule
